neuron_accum: RTL and testbench



---
 rtl/neuron_accum.sv | 127 ++++++++++++
 tb/tb_neuron_accum.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accum.sv
// Neuron MAC stage: Q8.8 pairs onto a bias, saturated to 16 bits.
// Optional ReLU clamp on the result when NEURON_RELU_EN is defined.
module neuron_accum #(
  parameter int N_IN  = 8,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] bias_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_x_i,
  input  logic [15:0] in_w_i,
  output logic [15:0] out_val_o,
  output logic        out_load_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SAT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             val_q, val_d;

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] r;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic [15:0]             sat;
  logic [15:0]             res;
  logic                    accept;
  logic                    last;

  assign prod     = $signed(in_x_i) * $signed(in_w_i);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign bias_ext = {{(ACC_W-24){bias_i[15]}}, bias_i, 8'h00};

  // Q16.16 -> Q8.8 by arithmetic shift, i.e. floor rounding
  assign r       = acc_q >>> 8;
  assign pos_ovf = !r[ACC_W-1] && (|r[ACC_W-2:15]);
  assign neg_ovf = r[ACC_W-1] && !(&r[ACC_W-2:15]);

  always_comb begin
    sat = r[15:0];
    if (pos_ovf) begin
      sat = 16'h7FFF;
    end else if (neg_ovf) begin
      sat = 16'h8000;
    end
  end

`ifdef NEURON_RELU_EN
  assign res = sat[15] ? 16'h0000 : sat;
`else
  assign res = sat;
`endif

  assign accept = (state_q == S_ACCUM) && in_valid_i;
  assign last   = (cnt_q == CNT_W'(N_IN - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_SAT;
          end
        end
      end
      S_SAT: begin
        val_d   = res;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign in_ready_o = (state_q == S_ACCUM);
  assign out_load_o = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign out_val_o  = val_q;

endmodule

// File: tb/tb_neuron_accum.sv
// Directed bench for neuron_accum: one N_IN=2 and one N_IN=8 instance.
// Expected values are hand-computed Q8.8 results.
module tb_neuron_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start2 = 0, v2 = 0;
  logic [15:0] bias2 = 0, x2 = 0, w2 = 0;
  logic        rdy2, ld2, busy2;
  logic [15:0] val2;

  logic        start8 = 0, v8 = 0;
  logic [15:0] bias8 = 0, x8 = 0, w8 = 0;
  logic        rdy8, ld8, busy8;
  logic [15:0] val8;

  int errors = 0;
  int checks = 0;

`ifdef NEURON_RELU_EN
  localparam logic [15:0] EXP_NEG1 = 16'h0000;
  localparam logic [15:0] EXP_FLR  = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG1 = 16'hFE00;
  localparam logic [15:0] EXP_FLR  = 16'hFFFF;
`endif

  always #5 clk = ~clk;

  neuron_accum #(.N_IN(2), .ACC_W(40)) u_dut2 (
    .clk(clk), .rst(rst),
    .start_i(start2), .bias_i(bias2),
    .in_valid_i(v2), .in_ready_o(rdy2),
    .in_x_i(x2), .in_w_i(w2),
    .out_val_o(val2), .out_load_o(ld2),
    .busy_o(busy2)
  );

  neuron_accum #(.N_IN(8), .ACC_W(40)) u_dut8 (
    .clk(clk), .rst(rst),
    .start_i(start8), .bias_i(bias8),
    .in_valid_i(v8), .in_ready_o(rdy8),
    .in_x_i(x8), .in_w_i(w8),
    .out_val_o(val8), .out_load_o(ld8),
    .busy_o(busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called just after the edge that accepted the last pair
  task automatic wait_ld2(output logic [15:0] v, output int n);
    n = 1;
    while (!ld2 && n < 20) begin
      tick();
      n++;
    end
    v = val2;
    if (!ld2) n = -1;
  endtask

  task automatic wait_ld8(output logic [15:0] v, output int n);
    n = 1;
    while (!ld8 && n < 20) begin
      tick();
      n++;
    end
    v = val8;
    if (!ld8) n = -1;
  endtask

  task automatic feed2(input logic [15:0] b,
                       input logic [15:0] xa, wa,
                       input logic [15:0] xb, wb,
                       output logic [15:0] v, output int n);
    start2 = 1; bias2 = b;
    tick();
    start2 = 0;
    v2 = 1; x2 = xa; w2 = wa;
    tick();
    x2 = xb; w2 = wb;
    tick();
    v2 = 0;
    wait_ld2(v, n);
  endtask

  task automatic feed8(input logic [15:0] b,
                       input logic [15:0] x, w,
                       output logic [15:0] v, output int n);
    start8 = 1; bias8 = b;
    tick();
    start8 = 0;
    v8 = 1; x8 = x; w8 = w;
    repeat (8) tick();
    v8 = 0;
    wait_ld8(v, n);
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    checks++;
    if ({val2, ld2, rdy2, busy2} !== 19'h0) begin
      errors++;
      $display("FAIL reset2: val=%h ld=%b rdy=%b busy=%b, want all 0",
               val2, ld2, rdy2, busy2);
    end
    checks++;
    if ({val8, ld8, rdy8, busy8} !== 19'h0) begin
      errors++;
      $display("FAIL reset8: val=%h ld=%b rdy=%b busy=%b, want all 0",
               val8, ld8, rdy8, busy8);
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] v;
    int n;
    feed2(16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'h0100, v, n);
    checks++;
    if (v !== 16'h0280) begin
      errors++;
      $display("FAIL basic_val: got %h want 0280", v);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL basic_lat: got %0d want 2", n);
    end
    tick();
    checks++;
    if (ld2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: ld=%b busy=%b want 0 0", ld2, busy2);
    end
  endtask

  task automatic test_sat();
    logic [15:0] v;
    int n;
    feed8(16'h7FFF, 16'h7FFF, 16'h7FFF, v, n);
    checks++;
    if (v !== 16'h7FFF || n !== 2) begin
      errors++;
      $display("FAIL sat_pos: got %h lat %0d want 7fff lat 2", v, n);
    end
    tick();
    feed8(16'h7FFF, 16'h7FFF, 16'h8000, v, n);
    checks++;
    if (v !== 16'h8000 || n !== 2) begin
      errors++;
      $display("FAIL sat_neg: got %h lat %0d want 8000 lat 2", v, n);
    end
    tick();
  endtask

  task automatic test_relu();
    logic [15:0] v;
    int n;
    feed2(16'hFF00, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, v, n);
    checks++;
    if (v !== EXP_NEG1) begin
      errors++;
      $display("FAIL neg_bias: got %h want %h", v, EXP_NEG1);
    end
    tick();
    feed2(16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, v, n);
    checks++;
    if (v !== EXP_FLR) begin
      errors++;
      $display("FAIL floor_round: got %h want %h", v, EXP_FLR);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] xs [2];
    logic [15:0] ws [2];
    logic [15:0] v;
    int n;
    int idle_seen = 0;
    xs[0] = 16'h0100; ws[0] = 16'h0200;
    xs[1] = 16'h0080; ws[1] = 16'h0100;
    start2 = 1; bias2 = 16'h0000;
    tick();
    for (int k = 0; k < 2; k++) begin
      v2 = 0;
      start2 = (k == 0);
      bias2 = 16'h7FFF;
      tick();
      start2 = 0;
      if (!busy2) idle_seen++;
      v2 = 1; x2 = xs[k]; w2 = ws[k];
      tick();
      if (!busy2) idle_seen++;
    end
    v2 = 0;
    wait_ld2(v, n);
    checks++;
    if (idle_seen !== 0) begin
      errors++;
      $display("FAIL stall_busy: idle cycles %0d want 0", idle_seen);
    end
    checks++;
    if (v !== 16'h0280 || n !== 2) begin
      errors++;
      $display("FAIL stall_val: got %h lat %0d want 0280 lat 2", v, n);
    end
    tick();
    tick();
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL stall_noqueue: busy=%b want 0", busy2);
    end
  endtask

  task automatic test_abort();
    logic [15:0] v;
    int n;
    int bad = 0;
    start2 = 1; bias2 = 16'h0000;
    tick();
    start2 = 0;
    v2 = 1; x2 = 16'h0100; w2 = 16'h0200;
    tick();
    v2 = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({val2, ld2, rdy2, busy2} !== 19'h0) begin
      errors++;
      $display("FAIL abort_rst: val=%h ld=%b rdy=%b busy=%b want 0",
               val2, ld2, rdy2, busy2);
    end
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ld2 || val2 !== 16'h0000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d bad cycles want 0", bad);
    end
    feed2(16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'h0100, v, n);
    checks++;
    if (v !== 16'h0280) begin
      errors++;
      $display("FAIL abort_rerun: got %h want 0280", v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t[$];
    int consec = 0;
    int bad = 0;
    logic prev = 0;
    start8 = 1; bias8 = 16'h0000;
    v8 = 1; x8 = 16'h0100; w8 = 16'h0100;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ld8) begin
        t.push_back(i);
        if (val8 !== 16'h0800) bad++;
        if (prev) consec++;
      end
      prev = ld8;
    end
    start8 = 0;
    for (int i = 0; i < 20 && busy8; i++) tick();
    v8 = 0;
    checks++;
    if (t.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want >=3", t.size());
    end else begin
      checks++;
      if (t[1] - t[0] !== 11 || t[2] - t[1] !== 11) begin
        errors++;
        $display("FAIL b2b_period: got %0d,%0d want 11,11",
                 t[1] - t[0], t[2] - t[1]);
      end
    end
    checks++;
    if (consec !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL b2b_pulse: consec=%0d badval=%0d want 0 0",
               consec, bad);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b want 0", busy8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_relu();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
